rs_deint_syndrome: RTL and testbench

//  Parametrised front half of the Reed-Solomon path in the LRPT decoder.
//  - Accepts the descrambled CVCDU byte stream and de-interleaves it round-robin into INTERLEAVE codewords.
//  - Computes NROOTS syndromes per codeword on the fly (Horner, one byte/cycle).
//  - Drains the syndromes over a valid/ready port, with a per-codeword clean flag, to the downstream BM/Chien/Forney stage.

---
 rtl/rs_deint_syndrome.sv | 157 +++++++++++++++
 tb/tb_rs_deint_syndrome.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_deint_syndrome.sv
// rtl/rs_deint_syndrome.sv - LRPT RS de-interleaver and per-codeword syndrome generator
// Optional: RS_DUAL_BASIS_EN converts CCSDS dual-basis input bytes to conventional basis.
module rs_deint_syndrome #(
  parameter int         INTERLEAVE = 4,
  parameter int         N          = 255,
  parameter int         NROOTS     = 32,
  parameter int         FCR        = 112,
  parameter int         PRIM       = 11,
  parameter logic [8:0] GF_POLY    = 9'h187
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          new_cvcdu_in,
  input  logic                          symbol_valid_in,
  input  logic [7:0]                    symbol_in,
  output logic                          symbol_ready_out,
  output logic                          syn_valid_out,
  input  logic                          syn_ready_in,
  output logic [$clog2(INTERLEAVE)-1:0] syn_cw_out,
  output logic [$clog2(NROOTS)-1:0]     syn_idx_out,
  output logic [7:0]                    syn_out,
  output logic                          cw_ok_out,
  output logic                          frame_err_out
);

  localparam int FRAME = INTERLEAVE * N;
  localparam int BW    = $clog2(FRAME);
  localparam int CW_W  = $clog2(INTERLEAVE);
  localparam int IX_W  = $clog2(NROOTS);
  localparam logic [BW-1:0]   FRAME_LAST = BW'(FRAME - 1);
  localparam logic [BW-1:0]   IL_B       = BW'(INTERLEAVE);
  localparam logic [CW_W-1:0] LAST_CW    = CW_W'(INTERLEAVE - 1);
  localparam logic [IX_W-1:0] IX_LAST    = IX_W'(NROOTS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY[7:0] : 8'h00);
    end
    return p;
  endfunction

  // alpha^e by square-and-multiply; only evaluated at elaboration for the root constants
  function automatic logic [7:0] gf_pow_alpha(input int e);
    logic [7:0] r, b;
    int k;
    r = 8'h01;
    b = 8'h02;
    k = e % 255;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) r = gf_mul(r, b);
      b = gf_mul(b, b);
    end
    return r;
  endfunction

  state_t          state, state_nxt;
  logic [BW-1:0]   bcnt, eff_bcnt;
  logic [CW_W-1:0] ch, eff_ch, dcw;
  logic [IX_W-1:0] didx;
  logic [7:0]      syn [INTERLEAVE][NROOTS];
  logic [7:0]      prod [NROOTS];
  logic [7:0]      nxt [NROOTS];
  logic [INTERLEAVE-1:0] nz;
  logic [7:0]      sym;
  logic            accept, restart, write, first, nz_new, last_beat;

`ifdef RS_DUAL_BASIS_EN
  // Conventional-basis image of each dual-basis unit vector (columns of the inverse Berlekamp matrix)
  localparam logic [7:0] DUAL_COL [8] = '{8'hcc, 8'hac, 8'h79, 8'hf0, 8'hfd, 8'h2e, 8'h42, 8'hc5};
  always_comb begin
    sym = '0;
    for (int b = 0; b < 8; b++)
      if (symbol_in[b]) sym = sym ^ DUAL_COL[b];
  end
`else
  assign sym = symbol_in;
`endif

  assign symbol_ready_out = (state != DRAIN);
  assign accept   = symbol_valid_in & symbol_ready_out;
  assign restart  = accept & new_cvcdu_in;
  assign write    = accept & ((state == ACCUM) | new_cvcdu_in);
  assign eff_bcnt = restart ? '0 : bcnt;
  assign eff_ch   = restart ? '0 : ch;
  assign first    = (eff_bcnt < IL_B);
  assign last_beat = (dcw == LAST_CW) && (didx == IX_LAST);

  // One multiplier bank shared by all codewords; the active channel's syndromes are muxed in
  for (genvar j = 0; j < NROOTS; j++) begin : g_root
    localparam logic [7:0] ROOT = gf_pow_alpha(PRIM * (FCR + j));
    assign prod[j] = gf_mul(syn[eff_ch][j], ROOT);
  end

  always_comb begin
    nz_new = 1'b0;
    for (int j = 0; j < NROOTS; j++) begin
      nxt[j] = first ? sym : (prod[j] ^ sym);
      nz_new = nz_new | (nxt[j] != 8'h00);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (restart) state_nxt = ACCUM;
      ACCUM:   if (accept && (eff_bcnt == FRAME_LAST)) state_nxt = DRAIN;
      DRAIN:   if (syn_ready_in && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      bcnt          <= '0;
      ch            <= '0;
      dcw           <= '0;
      didx          <= '0;
      nz            <= '0;
      frame_err_out <= 1'b0;
      for (int c = 0; c < INTERLEAVE; c++)
        for (int j = 0; j < NROOTS; j++)
          syn[c][j] <= '0;
    end else begin
      state         <= state_nxt;
      frame_err_out <= restart && (state == ACCUM) && (bcnt != '0);
      if (write) begin
        for (int j = 0; j < NROOTS; j++)
          syn[eff_ch][j] <= nxt[j];
        nz[eff_ch] <= nz_new;
        bcnt <= (eff_bcnt == FRAME_LAST) ? '0 : eff_bcnt + BW'(1);
        ch   <= (eff_ch == LAST_CW) ? '0 : eff_ch + CW_W'(1);
      end
      if ((state == DRAIN) && syn_ready_in) begin
        if (didx == IX_LAST) begin
          didx <= '0;
          dcw  <= (dcw == LAST_CW) ? '0 : dcw + CW_W'(1);
        end else begin
          didx <= didx + IX_W'(1);
        end
      end
    end
  end

  assign syn_valid_out = (state == DRAIN);
  assign syn_cw_out    = syn_valid_out ? dcw : '0;
  assign syn_idx_out   = syn_valid_out ? didx : '0;
  assign syn_out       = syn_valid_out ? syn[dcw][didx] : 8'h00;
  assign cw_ok_out     = syn_valid_out && (didx == IX_LAST) && !nz[dcw];

endmodule

// File: tb/tb_rs_deint_syndrome.sv
// tb/tb_rs_deint_syndrome.sv - scoreboard bench for rs_deint_syndrome
`timescale 1ns/1ps
module tb_rs_deint_syndrome;

  localparam int IL = 4;
  localparam int NN = 255;
  localparam int NR = 32;
  localparam int FL = IL * NN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_cvcdu = 1'b0;
  logic       symbol_valid = 1'b0;
  logic [7:0] symbol = 8'h00;
  logic       symbol_ready;
  logic       syn_valid;
  logic       syn_ready = 1'b1;
  logic [1:0] syn_cw;
  logic [4:0] syn_idx;
  logic [7:0] syn;
  logic       cw_ok;
  logic       frame_err;

  always #5 clk = ~clk;

  rs_deint_syndrome dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .new_cvcdu_in    (new_cvcdu),
    .symbol_valid_in (symbol_valid),
    .symbol_in       (symbol),
    .symbol_ready_out(symbol_ready),
    .syn_valid_out   (syn_valid),
    .syn_ready_in    (syn_ready),
    .syn_cw_out      (syn_cw),
    .syn_idx_out     (syn_idx),
    .syn_out         (syn),
    .cw_ok_out       (cw_ok),
    .frame_err_out   (frame_err)
  );

  typedef struct {
    logic [1:0] cw;
    logic [4:0] idx;
    logic [7:0] s;
    logic       ok;
  } beat_t;

  beat_t      exp_q[$];
  beat_t      mb;
  logic [7:0] frm [FL];
  logic [7:0] root_t [NR];
  int         checks = 0;
  int         failures = 0;
  int         beats = 0;
  int         err_cycles = 0;
  bit         toggle_mode = 1'b0;
  bit         rdy_bad = 1'b0;
  bit         hold_bad = 1'b0;
  bit         hold_pend = 1'b0;
  logic [15:0] held;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ a;
      a = a[7] ? ((a << 1) ^ 8'h87) : (a << 1);
    end
    return r;
  endfunction

  // Direct polynomial evaluation: S_j = sum r_i * root_j^(N-1-i)
  task automatic push_expected();
    beat_t b;
    logic [7:0] s, pw;
    bit all_zero;
    for (int c = 0; c < IL; c++) begin
      logic [7:0] sv [NR];
      all_zero = 1'b1;
      for (int j = 0; j < NR; j++) begin
        s = 8'h00;
        pw = 8'h01;
        for (int i = NN - 1; i >= 0; i--) begin
          s = s ^ gmul(frm[i * IL + c], pw);
          pw = gmul(pw, root_t[j]);
        end
        sv[j] = s;
        if (s != 8'h00) all_zero = 1'b0;
      end
      for (int j = 0; j < NR; j++) begin
        b.cw = 2'(c);
        b.idx = 5'(j);
        b.s = sv[j];
        b.ok = (j == NR - 1) ? all_zero : 1'b0;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic send_bytes(input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      symbol_valid = 1'b1;
      symbol = frm[i];
      new_cvcdu = (i == 0);
      @(posedge clk); #1;
    end
    symbol_valid = 1'b0;
    new_cvcdu = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input bit offer);
    int n = 0;
    while ((syn_valid || exp_q.size() != 0) && n < 2000) begin
      symbol_valid = offer;
      new_cvcdu = offer;
      symbol = 8'($urandom);
      @(posedge clk); #1;
      n++;
    end
    symbol_valid = 1'b0;
    new_cvcdu = 1'b0;
    check_eq({tag, "_timeout"}, n < 2000, 1);
    check_eq({tag, "_left"}, exp_q.size(), 0);
    check_eq({tag, "_ready_in_drain"}, rdy_bad, 0);
    check_eq({tag, "_hold"}, hold_bad, 0);
    rdy_bad = 1'b0;
    hold_bad = 1'b0;
    exp_q.delete();
  endtask

  task automatic fill_random();
    for (int i = 0; i < FL; i++) frm[i] = 8'($urandom);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      syn_ready = toggle_mode ? ~syn_ready : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (frame_err) err_cycles++;
    if (rst_n && syn_valid) begin
      if (symbol_ready) rdy_bad = 1'b1;
      if (hold_pend && ({syn_cw, syn_idx, syn, cw_ok} != held)) hold_bad = 1'b1;
      hold_pend = !syn_ready;
      held = {syn_cw, syn_idx, syn, cw_ok};
      if (syn_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", 1, 0);
        end else begin
          mb = exp_q.pop_front();
          check_eq("beat_cw", syn_cw, mb.cw);
          check_eq("beat_idx", syn_idx, mb.idx);
          check_eq($sformatf("syn_cw%0d_j%0d", mb.cw, mb.idx), syn, mb.s);
          check_eq($sformatf("ok_cw%0d_j%0d", mb.cw, mb.idx), cw_ok, mb.ok);
        end
        beats++;
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    logic [7:0] p;
    for (int j = 0; j < NR; j++) begin
      p = 8'h01;
      repeat ((11 * (112 + j)) % 255) p = gmul(p, 8'h02);
      root_t[j] = p;
    end

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_symbol_ready", symbol_ready, 1);
    check_eq("rst_syn_valid", syn_valid, 0);
    check_eq("rst_syn_out", syn, 0);
    check_eq("rst_cw_ok", cw_ok, 0);
    check_eq("rst_frame_err", frame_err, 0);
    check_eq("rst_syn_cw_idx", {syn_cw, syn_idx}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Bytes without new_cvcdu in IDLE are dropped
    for (int i = 0; i < 5; i++) begin
      symbol_valid = 1'b1;
      symbol = 8'($urandom_range(1, 255));
      new_cvcdu = 1'b0;
      @(posedge clk); #1;
    end
    symbol_valid = 1'b0;
    check_eq("idle_drop_valid", syn_valid, 0);

    // All-zero frame
    for (int i = 0; i < FL; i++) frm[i] = 8'h00;
    push_expected();
    send_bytes(FL);
    wait_drain("zero", 1'b0);
    check_eq("zero_no_frame_err", err_cycles, 0);

    // Single nonzero last symbol of cw1
    frm[1017] = 8'h5A;
    push_expected();
    send_bytes(FL);
    wait_drain("last_sym", 1'b0);

    // Random frame, back-pressured drain, bytes offered during drain
    fill_random();
    push_expected();
    send_bytes(FL);
    toggle_mode = 1'b1;
    wait_drain("toggle", 1'b1);
    toggle_mode = 1'b0;
    @(posedge clk); #1;

    // Abort at bcnt=500 then a full new frame
    base = err_cycles;
    fill_random();
    send_bytes(500);
    fill_random();
    push_expected();
    send_bytes(FL);
    wait_drain("abort", 1'b0);
    check_eq("abort_err_pulse", err_cycles - base, 1);

    // Reset in the middle of drain at beat 40
    fill_random();
    push_expected();
    send_bytes(FL);
    base = beats;
    n = 0;
    while ((beats - base) < 40 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("mid_drain_reach", n < 2000, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_syn_valid", syn_valid, 0);
    check_eq("mid_rst_symbol_ready", symbol_ready, 1);
    check_eq("mid_rst_syn_out", syn, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_random();
    push_expected();
    send_bytes(FL);
    wait_drain("after_rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
